div_unit: RTL

- Iterative multi-cycle integer divider for the execute stage.
- The execute stage is the initiator: it drives start, operands and annul, and stalls the pipeline until ready.
- This block is the responder: it returns {remainder, quotient} for the HI/LO write-back.
- Implements MIPS DIV and DIVU with a one-bit-per-cycle restoring algorithm.

---
 rtl/div_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU.
// One quotient bit per cycle; returns {remainder, quotient}.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam int REM_W = 2 * DATA_W + 1;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [DATA_W-1:0]     divisor_q, divisor_d;
    logic                  sign_q_q, sign_q_d;
    logic                  sign_r_q, sign_r_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic                  a_neg, b_neg;
    logic [DATA_W-1:0]     a_mag, b_mag;
    logic                  div_zero;

    logic [REM_W-1:0]      shifted;
    logic [DATA_W:0]       trial;
    logic [REM_W-1:0]      step_rem;

    logic [DATA_W-1:0]     quot_raw, rem_raw;
    logic [DATA_W-1:0]     quot_fix, rem_fix;

    // Operand magnitudes and sign flags taken at the accepting edge
    always_comb begin
        a_neg    = signed_div_i & opdata1_i[DATA_W-1];
        b_neg    = signed_div_i & opdata2_i[DATA_W-1];
        a_mag    = a_neg ? ({DATA_W{1'b0}} - opdata1_i) : opdata1_i;
        b_mag    = b_neg ? ({DATA_W{1'b0}} - opdata2_i) : opdata2_i;
        div_zero = (opdata2_i == {DATA_W{1'b0}});
    end

    // One restoring step: shift, trial-subtract, keep or restore
    always_comb begin
        shifted = rem_q << 1;
        trial   = shifted[REM_W-1:DATA_W] - {1'b0, divisor_q};
        if (trial[DATA_W]) begin
            step_rem = shifted;
        end else begin
            step_rem = {trial, shifted[DATA_W-1:1], 1'b1};
        end
    end

    // Final sign correction of quotient and remainder
    always_comb begin
        quot_raw = rem_q[DATA_W-1:0];
        rem_raw  = rem_q[2*DATA_W-1:DATA_W];
        quot_fix = sign_q_q ? ({DATA_W{1'b0}} - quot_raw) : quot_raw;
        rem_fix  = sign_r_q ? ({DATA_W{1'b0}} - rem_raw) : rem_raw;
    end

    // Control FSM and datapath next-state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        sign_q_d  = sign_q_q;
        sign_r_d  = sign_r_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            S_IDLE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    if (div_zero) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d   = S_ON;
                        cnt_d     = '0;
                        rem_d     = {{(DATA_W + 1){1'b0}}, a_mag};
                        divisor_d = b_mag;
                        sign_q_d  = a_neg ^ b_neg;
                        sign_r_d  = a_neg;
                    end
                end
            end

            S_BYZERO: begin
                if (annul_i) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    state_d  = S_END;
                    ready_d  = 1'b1;
                    result_d = '0;
                end
            end

            S_ON: begin
                if (annul_i) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_END;
                    ready_d  = 1'b1;
                    result_d = {rem_fix, quot_fix};
                end else begin
                    rem_d = step_rem;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_END: begin
                if (!start_i) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = S_IDLE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            sign_q_q  <= sign_q_d;
            sign_r_q  <= sign_r_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
